// File: rtl/ddr3_fsm.sv
// ddr3_fsm: row/bank management and refresh scheduler feeding the DDR3 DFI
// command stage. It tracks the open row of each of the 8 banks. It turns flat
// read/write requests into PRECHARGE / ACTIVATE / READ / WRITE sequences and
// inserts a PRECHARGE-ALL + REFRESH pair every REFRESH_CYCLES clocks.
// Device timing is enforced downstream; this block only orders commands.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   enable_i               DRAM initialised; gates command issue and refresh timer
//   mem_req_i/mem_wrt_i    upstream request (held until mem_rdy_o) and direction
//   mem_pre_i              auto-precharge after this access
//   mem_addr_i             {row, bank, col}
//   mem_rdy_o              one-cycle pulse on the READ/WRIT transfer
//   request_o/accept_i     command handshake to the DFI stage
//   command_o              {CS#,RAS#,CAS#,WE#}; NOOP while request_o is low
//   autopre_o, bank_o, addr_o  command qualifiers
module ddr3_fsm #(
  parameter int DDR_ROW_BITS   = 15,
  parameter int DDR_COL_BITS   = 9,
  parameter int REFRESH_CYCLES = 780
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   enable_i,
  input  logic                                   mem_req_i,
  input  logic                                   mem_wrt_i,
  input  logic                                   mem_pre_i,
  input  logic [DDR_ROW_BITS+3+DDR_COL_BITS-1:0] mem_addr_i,
  output logic                                   mem_rdy_o,
  output logic                                   request_o,
  output logic [3:0]                             command_o,
  output logic                                   autopre_o,
  input  logic                                   accept_i,
  output logic [2:0]                             bank_o,
  output logic [DDR_ROW_BITS-1:0]                addr_o
);

  localparam int DDR_BANK_BITS = 3;
  localparam int NUM_BANKS     = 1 << DDR_BANK_BITS;
  localparam int TIMER_BITS    = $clog2(REFRESH_CYCLES + 1);

  localparam logic [3:0] CMD_NOOP = 4'b0111;
  localparam logic [3:0] CMD_READ = 4'b0101;
  localparam logic [3:0] CMD_WRIT = 4'b0100;
  localparam logic [3:0] CMD_ACTV = 4'b0011;
  localparam logic [3:0] CMD_PREC = 4'b0010;
  localparam logic [3:0] CMD_REFR = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PREC, ST_ACTV, ST_RDWR, ST_PREA, ST_REFR
  } state_t;

  state_t state_q, state_d;

  // Request address fields.
  logic [DDR_ROW_BITS-1:0]  req_row;
  logic [DDR_BANK_BITS-1:0] req_bank;
  logic [DDR_COL_BITS-1:0]  req_col;
  assign req_row  = mem_addr_i[DDR_COL_BITS+DDR_BANK_BITS +: DDR_ROW_BITS];
  assign req_bank = mem_addr_i[DDR_COL_BITS +: DDR_BANK_BITS];
  assign req_col  = mem_addr_i[DDR_COL_BITS-1:0];

  // Per-bank open flag and open row.
  logic [NUM_BANKS-1:0]    open_q;
  logic [DDR_ROW_BITS-1:0] row_q [NUM_BANKS];
  logic                    any_open, row_hit;
  assign any_open = |open_q;
  assign row_hit  = open_q[req_bank] && (row_q[req_bank] == req_row);

  // Refresh timer.
  logic [TIMER_BITS-1:0] refr_cnt_q;
  logic                  refr_pend_q, refr_expire, refr_done;
  assign refr_expire = enable_i && (refr_cnt_q == TIMER_BITS'(REFRESH_CYCLES - 1));

  logic xfer;
  assign xfer = request_o && accept_i;

  logic open_set, open_clr_one, open_clr_all;

  // Next command register contents.
  logic                    req_d, autopre_d;
  logic [3:0]              cmd_d;
  logic [2:0]              bank_d;
  logic [DDR_ROW_BITS-1:0] addr_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    req_d        = request_o;
    cmd_d        = command_o;
    bank_d       = bank_o;
    addr_d       = addr_o;
    autopre_d    = autopre_o;
    open_set     = 1'b0;
    open_clr_one = 1'b0;
    open_clr_all = 1'b0;
    refr_done    = 1'b0;
    mem_rdy_o    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          if (refr_pend_q)    state_d = any_open ? ST_PREA : ST_REFR;
          else if (mem_req_i) state_d = row_hit ? ST_RDWR
                                      : (open_q[req_bank] ? ST_PREC : ST_ACTV);
        end
      end
      ST_PREC: if (xfer) begin
        open_clr_one = 1'b1;
        state_d      = enable_i ? ST_ACTV : ST_IDLE;
      end
      ST_ACTV: if (xfer) begin
        open_set = 1'b1;
        state_d  = enable_i ? ST_RDWR : ST_IDLE;
      end
      ST_RDWR: if (xfer) begin
        mem_rdy_o    = 1'b1;
        open_clr_one = mem_pre_i;
        state_d      = ST_IDLE;
      end
      ST_PREA: if (xfer) begin
        open_clr_all = 1'b1;
        state_d      = enable_i ? ST_REFR : ST_IDLE;
      end
      ST_REFR: if (xfer) begin
        refr_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Command registers only reload on a state change. Leaving a command state
    // needs a transfer, so a stalled handshake keeps all fields frozen, and
    // the next command loads on the same edge as the transfer.
    if (state_d != state_q) begin
      req_d     = 1'b1;
      bank_d    = req_bank;
      addr_d    = '0;
      autopre_d = 1'b0;
      unique case (state_d)
        ST_PREC: cmd_d = CMD_PREC;
        ST_ACTV: begin
          cmd_d  = CMD_ACTV;
          addr_d = req_row;
        end
        ST_RDWR: begin
          cmd_d                      = mem_wrt_i ? CMD_WRIT : CMD_READ;
          addr_d[DDR_COL_BITS-1:0]   = req_col;
          addr_d[10]                 = mem_pre_i;
          autopre_d                  = mem_pre_i;
        end
        ST_PREA: begin
          cmd_d      = CMD_PREC;
          bank_d     = '0;
          addr_d[10] = 1'b1;
        end
        ST_REFR: begin
          cmd_d  = CMD_REFR;
          bank_d = '0;
        end
        default: begin
          req_d  = 1'b0;
          cmd_d  = CMD_NOOP;
          bank_d = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      request_o <= 1'b0;
      command_o <= CMD_NOOP;
      bank_o    <= '0;
      addr_o    <= '0;
      autopre_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      request_o <= req_d;
      command_o <= cmd_d;
      bank_o    <= bank_d;
      addr_o    <= addr_d;
      autopre_o <= autopre_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)             open_q           <= '0;
    else if (open_clr_all) open_q           <= '0;
    else if (open_set)     open_q[req_bank] <= 1'b1;
    else if (open_clr_one) open_q[req_bank] <= 1'b0;
  end

  // NOTE: the row store is not reset; a row is only read while its open flag
  // is set, and the flag is written together with the row.
  always_ff @(posedge clock) begin
    if (open_set) row_q[req_bank] <= req_row;
  end

  // Timer holds at 0 while disabled. An expiry while a refresh is already
  // pending is absorbed by the OR.
  always_ff @(posedge clock) begin
    if (reset) begin
      refr_cnt_q  <= '0;
      refr_pend_q <= 1'b0;
    end else begin
      if (!enable_i || refr_expire) refr_cnt_q <= '0;
      else                          refr_cnt_q <= refr_cnt_q + TIMER_BITS'(1);
      refr_pend_q <= (refr_pend_q && !refr_done) || refr_expire;
    end
  end

endmodule

// File: tb/tb_ddr3_fsm.sv
// Directed bench for ddr3_fsm. Instance dut uses the default refresh period.
// Instance dut_r uses a 16-cycle period for the refresh scenario. Both share
// stimulus; each is only checked in its own phase.
module tb_ddr3_fsm;

  localparam logic [3:0] NOOP = 4'b0111, READ = 4'b0101, WRIT = 4'b0100;
  localparam logic [3:0] ACTV = 4'b0011, PREC = 4'b0010, REFR = 4'b0001;

  logic        clock = 1'b0;
  logic        reset, enable_i, mem_req_i, mem_wrt_i, mem_pre_i, accept_i;
  logic [26:0] mem_addr_i;

  logic        mem_rdy_o, request_o, autopre_o;
  logic [3:0]  command_o;
  logic [2:0]  bank_o;
  logic [14:0] addr_o;

  logic        r_mem_rdy, r_request, r_autopre;
  logic [3:0]  r_command;
  logic [2:0]  r_bank;
  logic [14:0] r_addr;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  ddr3_fsm dut (
    .clock(clock), .reset(reset), .enable_i(enable_i),
    .mem_req_i(mem_req_i), .mem_wrt_i(mem_wrt_i), .mem_pre_i(mem_pre_i),
    .mem_addr_i(mem_addr_i), .mem_rdy_o(mem_rdy_o), .request_o(request_o),
    .command_o(command_o), .autopre_o(autopre_o), .accept_i(accept_i),
    .bank_o(bank_o), .addr_o(addr_o)
  );

  ddr3_fsm #(.REFRESH_CYCLES(16)) dut_r (
    .clock(clock), .reset(reset), .enable_i(enable_i),
    .mem_req_i(mem_req_i), .mem_wrt_i(mem_wrt_i), .mem_pre_i(mem_pre_i),
    .mem_addr_i(mem_addr_i), .mem_rdy_o(r_mem_rdy), .request_o(r_request),
    .command_o(r_command), .autopre_o(r_autopre), .accept_i(accept_i),
    .bank_o(r_bank), .addr_o(r_addr)
  );

  function automatic logic [26:0] mk(input logic [14:0] row, input logic [2:0] bank,
                                     input logic [8:0] col);
    return {row, bank, col};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the falling edge, well away from posedge.
  task automatic expect_cmd(input string tag, input bit use_r, input logic req,
                            input logic [3:0] cmd, input logic [2:0] bank,
                            input logic [14:0] addr, input logic ap, input logic rdy);
    #1;
    check({tag, ".req"},  use_r ? r_request : request_o, req);
    check({tag, ".cmd"},  use_r ? r_command : command_o, cmd);
    check({tag, ".bank"}, use_r ? r_bank    : bank_o,    bank);
    check({tag, ".addr"}, use_r ? r_addr    : addr_o,    addr);
    check({tag, ".ap"},   use_r ? r_autopre : autopre_o, ap);
    check({tag, ".rdy"},  use_r ? r_mem_rdy : mem_rdy_o, rdy);
  endtask

  task automatic go();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; enable_i = 1'b0; mem_req_i = 1'b0; mem_wrt_i = 1'b0;
    mem_pre_i = 1'b0; mem_addr_i = '0; accept_i = 1'b1;
    go(); go();
    expect_cmd("reset", 0, 0, NOOP, 0, 15'h0000, 0, 0);

    // Write bank 2 row 0x0123 col 0x010 into closed banks.
    reset = 1'b0; enable_i = 1'b1; mem_req_i = 1'b1; mem_wrt_i = 1'b1;
    mem_addr_i = mk(15'h0123, 3'd2, 9'h010);
    go(); expect_cmd("wr_actv", 0, 1, ACTV, 2, 15'h0123, 0, 0);
    go(); expect_cmd("wr_writ", 0, 1, WRIT, 2, 15'h0010, 0, 1);
    go(); expect_cmd("wr_idle", 0, 0, NOOP, 0, 15'h0000, 0, 0);

    // Row hit: single READ.
    mem_wrt_i = 1'b0; mem_addr_i = mk(15'h0123, 3'd2, 9'h018);
    go(); expect_cmd("hit_read", 0, 1, READ, 2, 15'h0018, 0, 1);
    go(); expect_cmd("hit_idle", 0, 0, NOOP, 0, 15'h0000, 0, 0);

    // Row miss: PREC, ACTV, READ.
    mem_addr_i = mk(15'h0456, 3'd2, 9'h018);
    go(); expect_cmd("miss_prec", 0, 1, PREC, 2, 15'h0000, 0, 0);
    go(); expect_cmd("miss_actv", 0, 1, ACTV, 2, 15'h0456, 0, 0);
    go(); expect_cmd("miss_read", 0, 1, READ, 2, 15'h0018, 0, 1);
    go(); expect_cmd("miss_idle", 0, 0, NOOP, 0, 15'h0000, 0, 0);

    // ACTV stalled for 5 cycles, then a single transfer.
    mem_addr_i = mk(15'h0055, 3'd4, 9'h001); accept_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      go(); expect_cmd("stall_actv", 0, 1, ACTV, 4, 15'h0055, 0, 0);
    end
    accept_i = 1'b1;
    go(); expect_cmd("stall_read", 0, 1, READ, 4, 15'h0001, 0, 1);
    go(); expect_cmd("stall_idle", 0, 0, NOOP, 0, 15'h0000, 0, 0);

    // Auto-precharge write, then the same row again needs ACTV.
    mem_wrt_i = 1'b1; mem_pre_i = 1'b1; mem_addr_i = mk(15'h0007, 3'd5, 9'h008);
    go(); expect_cmd("ap_actv", 0, 1, ACTV, 5, 15'h0007, 0, 0);
    go(); expect_cmd("ap_writ", 0, 1, WRIT, 5, 15'h0408, 1, 1);
    go(); expect_cmd("ap_idle", 0, 0, NOOP, 0, 15'h0000, 0, 0);
    mem_pre_i = 1'b0;
    go(); expect_cmd("ap_reactv", 0, 1, ACTV, 5, 15'h0007, 0, 0);

    // Reset while ACTV is stalled; bank 2 (open before) must be reactivated.
    accept_i = 1'b0;
    go(); expect_cmd("rst_stall", 0, 1, ACTV, 5, 15'h0007, 0, 0);
    reset = 1'b1;
    go(); expect_cmd("rst_mid", 0, 0, NOOP, 0, 15'h0000, 0, 0);
    reset = 1'b0; accept_i = 1'b1; mem_wrt_i = 1'b0;
    mem_addr_i = mk(15'h0456, 3'd2, 9'h018);
    go(); expect_cmd("rst_actv", 0, 1, ACTV, 2, 15'h0456, 0, 0);
    go(); expect_cmd("rst_read", 0, 1, READ, 2, 15'h0018, 0, 1);
    go(); expect_cmd("rst_idle", 0, 0, NOOP, 0, 15'h0000, 0, 0);

    // Refresh scenario on dut_r (period 16). Edge E0 is the reset edge.
    mem_req_i = 1'b0; reset = 1'b1;
    go();
    reset = 1'b0; mem_req_i = 1'b1; mem_addr_i = mk(15'h0010, 3'd0, 9'h000);
    go(); expect_cmd("r_b0_actv", 1, 1, ACTV, 0, 15'h0010, 0, 0);
    go(); expect_cmd("r_b0_read", 1, 1, READ, 0, 15'h0000, 0, 1);
    go(); mem_addr_i = mk(15'h0020, 3'd3, 9'h000);
    go(); expect_cmd("r_b3_actv", 1, 1, ACTV, 3, 15'h0020, 0, 0);
    go(); expect_cmd("r_b3_read", 1, 1, READ, 3, 15'h0000, 0, 1);
    go(); mem_req_i = 1'b0;                       // after E6
    repeat (9) go();                              // after E15: timer at 15
    expect_cmd("r_pre_exp", 1, 0, NOOP, 0, 15'h0000, 0, 0);
    go();                                         // after E16: refresh pending
    expect_cmd("r_exp_idle", 1, 0, NOOP, 0, 15'h0000, 0, 0);
    mem_req_i = 1'b1; mem_addr_i = mk(15'h0030, 3'd1, 9'h005);
    go(); expect_cmd("r_prea", 1, 1, PREC, 0, 15'h0400, 0, 0);
    go(); expect_cmd("r_refr", 1, 1, REFR, 0, 15'h0000, 0, 0);
    go(); expect_cmd("r_ref_idle", 1, 0, NOOP, 0, 15'h0000, 0, 0);
    go(); expect_cmd("r_b1_actv", 1, 1, ACTV, 1, 15'h0030, 0, 0);
    go(); expect_cmd("r_b1_read", 1, 1, READ, 1, 15'h0005, 0, 1);
    go(); mem_addr_i = mk(15'h0020, 3'd3, 9'h000);
    go(); expect_cmd("r_b3_reactv", 1, 1, ACTV, 3, 15'h0020, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
